// File: rtl/vector_list_sequencer_pkg.sv
// Shared definitions for the vector display-list sequencer: entry layout,
// command codes and FSM state encodings.
package vector_pkg;

  localparam int COORD_W = 12;
  localparam int ENTRY_W = 2 + 2 * COORD_W;

  localparam int CMD_MSB = ENTRY_W - 1;
  localparam int CMD_LSB = ENTRY_W - 2;
  localparam int X_MSB   = 2 * COORD_W - 1;
  localparam int X_LSB   = COORD_W;
  localparam int Y_MSB   = COORD_W - 1;
  localparam int Y_LSB   = 0;

  localparam logic [1:0] CMD_JUMP = 2'd0;
  localparam logic [1:0] CMD_DRAW = 2'd1;
  localparam logic [1:0] CMD_END  = 2'd2;
  localparam logic [1:0] CMD_RSVD = 2'd3;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH     = 3'd1;
  localparam logic [STATE_W-1:0] ST_DECODE    = 3'd2;
  localparam logic [STATE_W-1:0] ST_ISSUE     = 3'd3;
  localparam logic [STATE_W-1:0] ST_HOLDOFF   = 3'd4;
  localparam logic [STATE_W-1:0] ST_FRAME_END = 3'd5;

  function automatic logic [1:0] entry_cmd(input logic [ENTRY_W-1:0] e);
    return e[CMD_MSB:CMD_LSB];
  endfunction

endpackage

// File: rtl/vector_list_sequencer_if.sv
// Host-write, line-controller handshake and status signals of the sequencer.
interface vector_list_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic                          wr_en;
  logic [ADDR_W-1:0]             wr_addr;
  logic [vector_pkg::ENTRY_W-1:0] wr_data;
  logic                          swap_req;
  logic                          enable;

  // A command is accepted in the cycle draw or jump is high; they are only
  // raised while ready is already high, so every pulse is a completed transfer.
  logic                          ready;
  logic [vector_pkg::COORD_W-1:0] x;
  logic [vector_pkg::COORD_W-1:0] y;
  logic                          draw;
  logic                          jump;

  logic                          busy;
  logic                          frame_done;
  logic                          swap_ack;
  logic                          err_bad_cmd;
  logic [vector_pkg::STATE_W-1:0] dbg_state;

  modport master (
    output wr_en, wr_addr, wr_data, swap_req, enable, ready,
    input  x, y, draw, jump, busy, frame_done, swap_ack, err_bad_cmd, dbg_state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, swap_req, enable, ready,
    output x, y, draw, jump, busy, frame_done, swap_ack, err_bad_cmd, dbg_state
  );
endinterface

// File: rtl/vector_list_sequencer_display_list_ram.sv
// Both display-list banks in one RAM; the bank select is the address MSB.
module display_list_ram
  import vector_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W:0]    wr_addr,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic [ADDR_W:0]    rd_addr,
  output logic [ENTRY_W-1:0] rd_data
);

  logic [ENTRY_W-1:0] mem [0:(1 << (ADDR_W + 1)) - 1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vector_list_sequencer.sv
// Double-buffered display-list player: replays the front bank one command per
// controller ready and swaps banks only at a frame boundary.
module vector_list_sequencer
  import vector_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input logic                     clk,
  input logic                     reset_n,
  vector_list_sequencer_if.slave  bus
);

  localparam logic [ADDR_W:0] ADDR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [STATE_W-1:0] state;
  logic               front;
  logic               pending;
  logic [ADDR_W:0]    addr;   // top bit marks a wrap past the last entry
  logic               is_draw;
  logic               err;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [ENTRY_W-1:0] rd_data;
  logic [1:0]         cmd;
  logic               fire;

  display_list_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (bus.wr_en),
    .wr_addr ({~front, bus.wr_addr}),
    .wr_data (bus.wr_data),
    .rd_addr ({front, addr[ADDR_W-1:0]}),
    .rd_data (rd_data)
  );

  assign cmd  = entry_cmd(rd_data);
  assign fire = (state == ST_ISSUE) && bus.ready;

  // Pulses are decoded from state so an asynchronous reset drops them at once.
  assign bus.draw        = fire && is_draw;
  assign bus.jump        = fire && !is_draw;
  assign bus.frame_done  = (state == ST_FRAME_END);
  assign bus.swap_ack    = bus.frame_done && pending;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.err_bad_cmd = err;
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.dbg_state   = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      front   <= 1'b0;
      pending <= 1'b0;
    end else if (bus.swap_ack) begin
      // A request arriving in the swap cycle collapses into this swap.
      front   <= ~front;
      pending <= 1'b0;
    end else if (bus.swap_req) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      addr    <= '0;
      is_draw <= 1'b0;
      err     <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.enable) begin
            addr  <= '0;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          if (addr[ADDR_W] || cmd == CMD_END || cmd == CMD_RSVD) begin
            if (!addr[ADDR_W] && cmd == CMD_RSVD) begin
              err <= 1'b1;
            end
            state <= ST_FRAME_END;
          end else begin
            x_q     <= rd_data[X_MSB:X_LSB];
            y_q     <= rd_data[Y_MSB:Y_LSB];
            is_draw <= (cmd == CMD_DRAW);
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.ready) begin
            addr  <= addr + ADDR_ONE;
            state <= ST_HOLDOFF;
          end
        end
        // The controller needs a cycle to drop ready after accepting.
        ST_HOLDOFF: state <= ST_FETCH;
        ST_FRAME_END: begin
          addr  <= '0;
          state <= bus.enable ? ST_FETCH : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Directed bench for vector_list_sequencer: table-driven display lists plus
// hand-written handshake, swap, reserved-command, wrap and reset sequences.
module tb_vector_list_sequencer;
  import vector_pkg::*;

  localparam int ADDR_W = 10;
  localparam int W      = ENTRY_W;  // observed event = {tag, x, y}
  localparam logic [1:0] EV_JUMP    = 2'd0;
  localparam logic [1:0] EV_DRAW    = 2'd1;
  localparam logic [1:0] EV_FD      = 2'd2;
  localparam logic [1:0] EV_FD_SWAP = 2'd3;

  typedef struct {
    logic [1:0]         cmd;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [1:0]         exp_tag;
    logic [COORD_W-1:0] exp_x;
    logic [COORD_W-1:0] exp_y;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;

  vector_list_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
  vector_list_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  int pulse_cnt = 0;
  int swap_cnt  = 0;
  bit mon_on    = 1'b0;
  logic [W-1:0] mon_ev;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("excl_draw_jump", W'(bus.draw & bus.jump), '0);
      check("pulse_without_ready", W'((bus.draw | bus.jump) & ~bus.ready), '0);
      check("swap_without_frame_done", W'(bus.swap_ack & ~bus.frame_done), '0);
      if (bus.draw || bus.jump || bus.frame_done) begin
        if (bus.frame_done)
          mon_ev = {(bus.swap_ack ? EV_FD_SWAP : EV_FD), {(2 * COORD_W){1'b0}}};
        else
          mon_ev = {(bus.draw ? EV_DRAW : EV_JUMP), bus.x, bus.y};
        if (exp_q.size() > 0) check("event", mon_ev, exp_q.pop_front());
      end
      if (bus.draw || bus.jump) pulse_cnt++;
      if (bus.swap_ack) swap_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [ADDR_W-1:0] a, input vec_t v);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = {v.cmd, v.x, v.y};
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_swap();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
  endtask

  task automatic push_vec(input vec_t v);
    exp_q.push_back({v.exp_tag, v.exp_x, v.exp_y});
  endtask

  task automatic push_fd(input logic [1:0] tag);
    exp_q.push_back({tag, {(2 * COORD_W){1'b0}}});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      tick();
      c++;
    end
    check({"drain_", name}, W'(exp_q.size()), '0);
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c = 0;
    bus.enable = 1'b0;
    while (bus.busy && c < budget) begin
      tick();
      c++;
    end
    check({"idle_", name}, W'(bus.busy), '0);
  endtask

  // ---------------- stimulus ----------------
  vec_t basic [5];
  vec_t nlist [3];
  vec_t rsv   [2];
  vec_t v;
  int   c;
  int   last;
  int   pulses_before;

  initial begin
    basic[0] = '{CMD_JUMP, 12'd30, 12'd3,  EV_JUMP, 12'd30, 12'd3};
    basic[1] = '{CMD_DRAW, 12'd0,  12'd27, EV_DRAW, 12'd0,  12'd27};
    basic[2] = '{CMD_DRAW, 12'd30, 12'd30, EV_DRAW, 12'd30, 12'd30};
    basic[3] = '{CMD_DRAW, 12'd0,  12'd0,  EV_DRAW, 12'd0,  12'd0};
    basic[4] = '{CMD_END,  12'd0,  12'd0,  EV_FD,   12'd0,  12'd0};
    nlist[0] = '{CMD_JUMP, 12'd100,  12'd200, EV_JUMP, 12'd100,  12'd200};
    nlist[1] = '{CMD_DRAW, 12'd4095, 12'd0,   EV_DRAW, 12'd4095, 12'd0};
    nlist[2] = '{CMD_END,  12'd0,    12'd0,   EV_FD,   12'd0,    12'd0};
    rsv[0]   = '{CMD_JUMP, 12'd5, 12'd5, EV_JUMP, 12'd5, 12'd5};
    rsv[1]   = '{CMD_RSVD, 12'd7, 12'd9, EV_FD,   12'd0, 12'd0};

    reset_n      = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.swap_req = 1'b0;
    bus.enable   = 1'b0;
    bus.ready    = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Bootstrap: RAM starts undefined, so put END at entry 0 of both banks.
    write_entry('0, basic[4]);
    pulse_swap();
    bus.enable = 1'b1;
    c = 0;
    while (!bus.swap_ack && c < 6000) begin
      @(negedge clk);
      c++;
    end
    check("boot_swap_ack", W'(bus.swap_ack), W'(1'b1));
    tick();
    wait_idle("boot", 6000);
    write_entry('0, basic[4]);

    // Reset held with enable and ready high: everything quiet.
    bus.enable = 1'b1;
    bus.ready  = 1'b1;
    reset_n    = 1'b0;
    repeat (3) tick();
    check("rst_x",          W'(bus.x), '0);
    check("rst_y",          W'(bus.y), '0);
    check("rst_draw",       W'(bus.draw), '0);
    check("rst_jump",       W'(bus.jump), '0);
    check("rst_busy",       W'(bus.busy), '0);
    check("rst_frame_done", W'(bus.frame_done), '0);
    check("rst_swap_ack",   W'(bus.swap_ack), '0);
    check("rst_err",        W'(bus.err_bad_cmd), '0);
    check("rst_state",      W'(bus.dbg_state), W'(ST_IDLE));
    bus.enable = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    mon_on = 1'b1;

    // Empty list: frame_done every 3 cycles, no commands.
    pulse_cnt  = 0;
    bus.enable = 1'b1;
    last = -1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      c = 0;
      while (!bus.frame_done && c < 20) begin
        @(negedge clk);
        c++;
      end
      if (k > 0) check("empty_period", W'(cyc - last), W'(3));
      last = cyc;
    end
    check("empty_no_pulse", W'(pulse_cnt), '0);
    tick();
    wait_idle("empty", 20);

    // Basic frame: swap out of the empty bank, then the list repeats.
    for (int i = 0; i < 5; i++) write_entry(ADDR_W'(i), basic[i]);
    pulse_swap();
    push_fd(EV_FD_SWAP);
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 5; i++) push_vec(basic[i]);
    swap_cnt   = 0;
    bus.enable = 1'b1;
    wait_drain("basic", 200);
    wait_idle("basic", 50);
    check("basic_swap_count", W'(swap_cnt), W'(1));

    // Handshake: ready low 20 cycles before each command; enable drops
    // after the first command and the frame must still complete.
    bus.ready  = 1'b0;
    for (int i = 0; i < 5; i++) push_vec(basic[i]);
    bus.enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (20) tick();
      bus.ready = 1'b1;
      @(negedge clk);
      check("hs_pulse_on_ready", W'(bus.draw | bus.jump), W'(1'b1));
      @(posedge clk);
      #1;
      bus.ready  = 1'b0;
      bus.enable = 1'b0;
    end
    bus.ready = 1'b1;
    wait_drain("handshake", 50);
    wait_idle("handshake", 50);

    // Swap at boundary: rewrite back bank mid-frame, two swap requests.
    for (int i = 0; i < 4; i++) push_vec(basic[i]);
    push_fd(EV_FD_SWAP);
    for (int i = 0; i < 3; i++) push_vec(nlist[i]);
    swap_cnt   = 0;
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) write_entry(ADDR_W'(i), nlist[i]);
    pulse_swap();
    tick();
    pulse_swap();
    wait_drain("swap", 200);
    wait_idle("swap", 50);
    check("swap_count", W'(swap_cnt), W'(1));
    check("hold_x", W'(bus.x), W'(12'd4095));
    check("hold_y", W'(bus.y), '0);

    // Reserved command after a jump ends the frame and latches the error.
    check("err_clear", W'(bus.err_bad_cmd), '0);
    for (int i = 0; i < 2; i++) write_entry(ADDR_W'(i), rsv[i]);
    pulse_swap();
    push_vec(nlist[0]);
    push_vec(nlist[1]);
    push_fd(EV_FD_SWAP);
    for (int i = 0; i < 2; i++) push_vec(rsv[i]);
    bus.enable = 1'b1;
    wait_drain("reserved", 100);
    check("err_set", W'(bus.err_bad_cmd), W'(1'b1));
    wait_idle("reserved", 50);
    repeat (3) tick();
    check("err_sticky", W'(bus.err_bad_cmd), W'(1'b1));

    // Full bank with no END: 1024 draws, frame ends on wrap, restarts at 0.
    for (int i = 0; i < 1024; i++) begin
      v = '{CMD_DRAW, 12'(i), 12'(1023 - i), EV_DRAW, 12'(i), 12'(1023 - i)};
      write_entry(ADDR_W'(i), v);
    end
    pulse_swap();
    push_vec(rsv[0]);
    push_fd(EV_FD_SWAP);
    for (int i = 0; i < 1024; i++) exp_q.push_back({EV_DRAW, 12'(i), 12'(1023 - i)});
    push_fd(EV_FD);
    exp_q.push_back({EV_DRAW, 12'd0, 12'd1023});
    bus.enable = 1'b1;
    wait_drain("full", 6000);
    wait_idle("full", 5000);

    // Reset asserted mid-ISSUE drops the pulse within the same cycle.
    bus.ready  = 1'b0;
    bus.enable = 1'b1;
    c = 0;
    while (bus.dbg_state != ST_ISSUE && c < 10) begin
      tick();
      c++;
    end
    check("reach_issue", W'(bus.dbg_state), W'(ST_ISSUE));
    bus.ready = 1'b1;
    #1;
    check("pre_reset_draw", W'(bus.draw), W'(1'b1));
    reset_n = 1'b0;
    #1;
    check("async_draw", W'(bus.draw), '0);
    check("async_jump", W'(bus.jump), '0);
    check("async_busy", W'(bus.busy), '0);
    pulses_before = pulse_cnt;
    repeat (3) tick();
    check("rst_hold_frame_done", W'(bus.frame_done), '0);
    bus.enable = 1'b0;
    reset_n    = 1'b1;
    repeat (5) tick();
    check("post_reset_idle", W'(bus.busy), '0);
    check("post_reset_no_pulse", W'(pulse_cnt - pulses_before), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
